div_signed_seq: RTL and testbench
=================================

Name: div_signed_seq

Overview:
- Sequential signed integer divider: the inverse operation of the team's combinational signed N x M array multiplier.
- Takes a DW-bit two's-complement dividend and a VW-bit two's-complement divisor, and produces quotient and remainder with truncating (round-toward-zero) semantics.
- Algorithm is sign-magnitude: take absolute values, do an unsigned restoring division one bit per clock, then sign-correct.
- Used wherever a product from the multiplier datapath must be scaled back down; a start/busy/done handshake replaces a combinational array.

Parameters:
- DW, 8, dividend and quotient width in bits (two's complement), DW >= 2
- VW, 4, divisor and remainder width in bits (two's complement), 2 <= VW <= DW

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when the block is idle
- dividend  input  DW  signed dividend, sampled on the accepted start edge
- divisor  input  VW  signed divisor, sampled on the accepted start edge
- busy  output  1  high while a division is in progress
- done  output  1  one-cycle pulse; quotient, remainder and flags are valid
- quotient  output  DW  signed quotient
- remainder  output  VW  signed remainder; carries the dividend's sign
- div_by_zero  output  1  last operation had divisor == 0
- overflow  output  1  last operation was most-negative dividend / -1

Behaviour:
- Reset: state IDLE; busy, done, div_by_zero and overflow = 0; quotient and remainder = 0; internal registers cleared. A reset asserted mid-operation aborts the operation with no done pulse.
- States: IDLE -> CALC -> FIX -> IDLE.
- IDLE:
  - start=1 at a clock edge accepts the operands.
  - Registers |dividend| as an unsigned DW-bit value (the most negative value maps to 2^(DW-1)).
  - Registers |divisor| as an unsigned VW-bit value, the operand signs, and a step counter = DW.
  - busy goes 1, next state is CALC.
- CALC, one edge per bit, DW edges total:
  - Shift the partial remainder (VW+1 bits) left and bring in the next dividend MSB.
  - Trial-subtract |divisor|. If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - Counter decrements; when it reaches 0, go to FIX.
- FIX, one edge:
  - quotient = negated magnitude if the dividend sign and divisor sign differ, else the magnitude.
  - remainder = negated if the dividend is negative.
  - Flags are set (see special cases).
  - done=1 for exactly this one cycle; busy=0; next state is IDLE.
- Latency: the start edge is edge 0, and done is high in the cycle following edge DW+1. busy is high from after edge 0 until edge DW+1.
- Outputs hold their values after done until the next FIX edge. They do not clear on a new start.
- start while busy is ignored: operands are not resampled and there is no queueing.
- The cycle in which done=1 is IDLE, so start in that cycle is accepted (back-to-back throughput is DW+2 cycles).
- Divide by zero, detected at accept:
  - The operation still takes full latency.
  - Result: quotient = all ones, remainder = 0, div_by_zero = 1, overflow = 0.
- Overflow (dividend = -2^(DW-1) and divisor = -1):
  - quotient = -2^(DW-1) (wrapped), remainder = 0, overflow = 1.
- Both flags are cleared on every normal FIX.
- No other overflow is possible: |remainder| < |divisor| <= 2^(VW-1), so the remainder always fits in signed VW bits.
- Divisor = most-negative VW value: its magnitude 2^(VW-1) must be held without truncation in the unsigned VW-bit register.

Test Plan (DW=8, VW=4):
- Reset check: assert rst mid-CALC -> busy, done and all outputs are 0 immediately (asynchronous); no done follows; a subsequent start works normally.
- Positive operands: 100 / 7 -> done exactly 9 cycles after the start edge; quotient = 14 (0x0E), remainder = 2, both flags 0.
- Mixed signs:
  - -100 / 7 -> quotient = -14 (0xF2), remainder = -2 (0xE).
  - 100 / -7 -> quotient = -14, remainder = 2.
  - -100 / -8 -> quotient = 12, remainder = -4 (0xC).
- Special cases:
  - -128 / -1 -> quotient = 0x80, remainder = 0, overflow = 1.
  - -128 / 1 -> quotient = 0x80, overflow = 0.
  - 5 / 0 -> quotient = 0xFF, remainder = 0, div_by_zero = 1.
- Handshake:
  - start pulsed every cycle while busy -> only the first operation runs; operand changes during busy do not affect the result.
  - start in the done cycle -> second result follows 9 cycles later.
- Randomised sweep over all 256 x 16 operand pairs against a truncating-division reference model, including flags.

Source files
------------

// File: rtl/div_signed_seq_if.sv
// Handshake and operand/result bundle for the sequential signed divider.
interface div_signed_seq_if #(
    parameter int DW = 8,
    parameter int VW = 4
);
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;
    logic          overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/div_signed_seq.sv
// Sign-magnitude restoring divider: one quotient bit per clock, truncating
// toward zero, with divide-by-zero and most-negative/-1 overflow flags.
module div_signed_seq #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic              clk,
    input  logic              rst,
    div_signed_seq_if.slave   bus
);
    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] dvd_q, dvd_d;      // dividend magnitude shifts out, quotient bits shift in
    logic [VW:0]   rem_q, rem_d;
    logic [VW-1:0] dvs_q, dvs_d;
    logic          neg_dvd_q, neg_dvd_d;
    logic          neg_dvs_q, neg_dvs_d;
    logic          pend_dz_q, pend_dz_d;
    logic          pend_ov_q, pend_ov_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [DW-1:0] quo_q, quo_d;
    logic [VW-1:0] rmd_q, rmd_d;
    logic          dz_q, dz_d;
    logic          ov_q, ov_d;

    logic [VW:0]   shifted;
    logic [VW:0]   dvs_ext;

    assign shifted = {rem_q[VW-1:0], dvd_q[DW-1]};
    assign dvs_ext = {1'b0, dvs_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            neg_dvd_q <= 1'b0;
            neg_dvs_q <= 1'b0;
            pend_dz_q <= 1'b0;
            pend_ov_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            quo_q     <= '0;
            rmd_q     <= '0;
            dz_q      <= 1'b0;
            ov_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            neg_dvd_q <= neg_dvd_d;
            neg_dvs_q <= neg_dvs_d;
            pend_dz_q <= pend_dz_d;
            pend_ov_q <= pend_ov_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            quo_q     <= quo_d;
            rmd_q     <= rmd_d;
            dz_q      <= dz_d;
            ov_q      <= ov_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        neg_dvd_d = neg_dvd_q;
        neg_dvs_d = neg_dvs_q;
        pend_dz_d = pend_dz_q;
        pend_ov_d = pend_ov_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        quo_d     = quo_q;
        rmd_d     = rmd_q;
        dz_d      = dz_q;
        ov_d      = ov_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // Negation in the operand width maps the most negative value
                    // onto its unsigned magnitude 2^(W-1) without loss.
                    dvd_d     = bus.dividend[DW-1] ? -bus.dividend : bus.dividend;
                    dvs_d     = bus.divisor[VW-1] ? -bus.divisor : bus.divisor;
                    neg_dvd_d = bus.dividend[DW-1];
                    neg_dvs_d = bus.divisor[VW-1];
                    pend_dz_d = (bus.divisor == '0);
                    pend_ov_d = (bus.dividend == {1'b1, {(DW-1){1'b0}}}) &&
                                (bus.divisor == '1);
                    rem_d     = '0;
                    cnt_d     = CW'(DW);
                    busy_d    = 1'b1;
                    state_d   = CALC;
                end
            end
            CALC: begin
                if (shifted >= dvs_ext) begin
                    rem_d = shifted - dvs_ext;
                    dvd_d = {dvd_q[DW-2:0], 1'b1};
                end else begin
                    rem_d = shifted;
                    dvd_d = {dvd_q[DW-2:0], 1'b0};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
                if (pend_dz_q) begin
                    quo_d = '1;
                    rmd_d = '0;
                    dz_d  = 1'b1;
                    ov_d  = 1'b0;
                end else begin
                    // Overflow case needs no override: the wrapped negation of 2^(DW-1) is itself.
                    quo_d = (neg_dvd_q ^ neg_dvs_q) ? -dvd_q : dvd_q;
                    rmd_d = neg_dvd_q ? -rem_q[VW-1:0] : rem_q[VW-1:0];
                    dz_d  = 1'b0;
                    ov_d  = pend_ov_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rmd_q;
    assign bus.div_by_zero = dz_q;
    assign bus.overflow    = ov_q;
endmodule

// File: tb/tb_div_signed_seq.sv
// Directed and exhaustive checks of div_signed_seq at DW=8, VW=4.
module tb_div_signed_seq;
    localparam int DW = 8;
    localparam int VW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    div_signed_seq_if #(.DW(DW), .VW(VW)) bus ();

    div_signed_seq #(.DW(DW), .VW(VW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Pulses start for one edge and waits (bounded) for done; lat = -1 on timeout.
    task automatic do_op(input logic [DW-1:0] a, input logic [VW-1:0] b,
                         output int lat, output logic busy_seen);
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        busy_seen = bus.busy;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int   lat;
        logic bsy;
        logic seen_done;
        n_vec++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quotient !== 8'h00 ||
            bus.remainder !== 4'h0 || bus.div_by_zero !== 1'b0 || bus.overflow !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got busy=%b done=%b q=%h r=%h dz=%b ov=%b, want all 0",
                     bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        do_op(8'd100, 4'd7, lat, bsy);
        bus.dividend = 8'h9C;
        bus.divisor  = 4'd7;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_vec++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quotient !== 8'h00 ||
            bus.remainder !== 4'h0 || bus.div_by_zero !== 1'b0 || bus.overflow !== 1'b0) begin
            n_err++;
            $display("FAIL reset_midcalc: got busy=%b done=%b q=%h r=%h dz=%b ov=%b, want all 0",
                     bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        seen_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) seen_done = 1'b1;
        end
        n_vec++;
        if (seen_done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_no_done: got activity=%b want 0", seen_done);
        end
        do_op(8'd100, 4'd7, lat, bsy);
        n_vec++;
        if (lat !== 9 || bus.quotient !== 8'h0E || bus.remainder !== 4'h2) begin
            n_err++;
            $display("FAIL reset_recover: got lat=%0d q=%h r=%h want lat=9 q=0e r=2",
                     lat, bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_positive();
        int   lat;
        logic bsy;
        do_op(8'd100, 4'd7, lat, bsy);
        n_vec++;
        if (lat !== 9) begin
            n_err++;
            $display("FAIL pos_latency: got %0d want 9", lat);
        end
        n_vec++;
        if (bsy !== 1'b1 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL pos_busy: got busy_after_start=%b busy_at_done=%b want 1 0", bsy, bus.busy);
        end
        n_vec++;
        if (bus.quotient !== 8'h0E || bus.remainder !== 4'h2 ||
            bus.div_by_zero !== 1'b0 || bus.overflow !== 1'b0) begin
            n_err++;
            $display("FAIL pos_result: got q=%h r=%h dz=%b ov=%b want 0e 2 0 0",
                     bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow);
        end
        @(posedge clk); #1;
        n_vec++;
        if (bus.done !== 1'b0 || bus.quotient !== 8'h0E) begin
            n_err++;
            $display("FAIL pos_hold: got done=%b q=%h want 0 0e", bus.done, bus.quotient);
        end
    endtask

    task automatic test_mixed_signs();
        int   lat;
        logic bsy;
        do_op(8'h9C, 4'd7, lat, bsy);
        n_vec++;
        if (lat !== 9 || bus.quotient !== 8'hF2 || bus.remainder !== 4'hE) begin
            n_err++;
            $display("FAIL neg_dvd: got lat=%0d q=%h r=%h want 9 f2 e", lat, bus.quotient, bus.remainder);
        end
        do_op(8'd100, 4'h9, lat, bsy);
        n_vec++;
        if (lat !== 9 || bus.quotient !== 8'hF2 || bus.remainder !== 4'h2) begin
            n_err++;
            $display("FAIL neg_dvs: got lat=%0d q=%h r=%h want 9 f2 2", lat, bus.quotient, bus.remainder);
        end
        do_op(8'h9C, 4'h8, lat, bsy);
        n_vec++;
        if (lat !== 9 || bus.quotient !== 8'h0C || bus.remainder !== 4'hC ||
            bus.overflow !== 1'b0 || bus.div_by_zero !== 1'b0) begin
            n_err++;
            $display("FAIL neg_both: got lat=%0d q=%h r=%h ov=%b dz=%b want 9 0c c 0 0",
                     lat, bus.quotient, bus.remainder, bus.overflow, bus.div_by_zero);
        end
    endtask

    task automatic test_special();
        int   lat;
        logic bsy;
        do_op(8'h80, 4'hF, lat, bsy);
        n_vec++;
        if (lat !== 9 || bus.quotient !== 8'h80 || bus.remainder !== 4'h0 ||
            bus.overflow !== 1'b1 || bus.div_by_zero !== 1'b0) begin
            n_err++;
            $display("FAIL ovf: got lat=%0d q=%h r=%h ov=%b dz=%b want 9 80 0 1 0",
                     lat, bus.quotient, bus.remainder, bus.overflow, bus.div_by_zero);
        end
        do_op(8'h80, 4'h1, lat, bsy);
        n_vec++;
        if (lat !== 9 || bus.quotient !== 8'h80 || bus.remainder !== 4'h0 ||
            bus.overflow !== 1'b0 || bus.div_by_zero !== 1'b0) begin
            n_err++;
            $display("FAIL minneg_by_1: got lat=%0d q=%h r=%h ov=%b dz=%b want 9 80 0 0 0",
                     lat, bus.quotient, bus.remainder, bus.overflow, bus.div_by_zero);
        end
        do_op(8'd5, 4'h0, lat, bsy);
        n_vec++;
        if (lat !== 9 || bus.quotient !== 8'hFF || bus.remainder !== 4'h0 ||
            bus.div_by_zero !== 1'b1 || bus.overflow !== 1'b0) begin
            n_err++;
            $display("FAIL div_zero: got lat=%0d q=%h r=%h dz=%b ov=%b want 9 ff 0 1 0",
                     lat, bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow);
        end
        do_op(8'd127, 4'h8, lat, bsy);
        n_vec++;
        if (lat !== 9 || bus.quotient !== 8'hF1 || bus.remainder !== 4'h7 ||
            bus.div_by_zero !== 1'b0 || bus.overflow !== 1'b0) begin
            n_err++;
            $display("FAIL minneg_dvs: got lat=%0d q=%h r=%h dz=%b ov=%b want 9 f1 7 0 0",
                     lat, bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow);
        end
    endtask

    task automatic test_busy_ignore();
        int lat;
        bus.dividend = 8'd100;
        bus.divisor  = 4'd7;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            bus.dividend = 8'(k * 3);
            bus.divisor  = 4'(k + 1);
            bus.start    = 1'b1;
            @(posedge clk); #1;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        bus.start = 1'b0;
        n_vec++;
        if (lat !== 9 || bus.quotient !== 8'h0E || bus.remainder !== 4'h2) begin
            n_err++;
            $display("FAIL busy_ignore: got lat=%0d q=%h r=%h want 9 0e 2", lat, bus.quotient, bus.remainder);
        end
        @(posedge clk); #1;
        n_vec++;
        if (bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL busy_no_queue: got busy=%b want 0", bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        int   lat1, lat2;
        logic bsy;
        logic [7:0] q1;
        logic [3:0] r1;
        do_op(8'd100, 4'd7, lat1, bsy);
        q1 = bus.quotient;
        r1 = bus.remainder;
        do_op(8'h9C, 4'h8, lat2, bsy);
        n_vec++;
        if (lat1 !== 9 || lat2 !== 9 || q1 !== 8'h0E || r1 !== 4'h2 ||
            bus.quotient !== 8'h0C || bus.remainder !== 4'hC) begin
            n_err++;
            $display("FAIL back_to_back: got lat=%0d/%0d q=%h/%h r=%h/%h want 9/9 0e/0c 2/c",
                     lat1, lat2, q1, bus.quotient, r1, bus.remainder);
        end
    endtask

    task automatic test_sweep();
        int         lat, qi, ri, shown;
        logic       bsy;
        logic [7:0] eq;
        logic [3:0] er;
        logic       edz, eov;
        shown = 0;
        for (int a = -128; a <= 127; a++) begin
            for (int b = -8; b <= 7; b++) begin
                if (b == 0) begin
                    eq = 8'hFF; er = 4'h0; edz = 1'b1; eov = 1'b0;
                end else if (a == -128 && b == -1) begin
                    eq = 8'h80; er = 4'h0; edz = 1'b0; eov = 1'b1;
                end else begin
                    qi = a / b;
                    ri = a % b;
                    eq = 8'(qi); er = 4'(ri); edz = 1'b0; eov = 1'b0;
                end
                do_op(8'(a), 4'(b), lat, bsy);
                n_vec++;
                if (lat !== 9 || bus.quotient !== eq || bus.remainder !== er ||
                    bus.div_by_zero !== edz || bus.overflow !== eov) begin
                    n_err++;
                    if (shown < 10) begin
                        shown++;
                        $display("FAIL sweep %0d/%0d: got lat=%0d q=%h r=%h dz=%b ov=%b want 9 %h %h %b %b",
                                 a, b, lat, bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow,
                                 eq, er, edz, eov);
                    end
                end
            end
        end
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        #2;
        test_reset();
        test_positive();
        test_mixed_signs();
        test_special();
        test_busy_ignore();
        test_back_to_back();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
